// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and baud helper
//
// Contents:
//   DATA_BITS      data bits per frame
//   MAX_STOP_BITS  largest supported stop-bit count, sizes the stop-bit index
//   uart_state_e   frame FSM state encoding, shared by transmit and receive sides
//   baud_divisor() clk cycles per bit, rounded to nearest

package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam int MAX_STOP_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Rounded rather than truncated so the bit-time error is at most half a clk.
  function automatic int baud_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO with extra-MSB full/empty pointers
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset, empties the FIFO
//   push     in   write din this edge; ignored while full
//   din      in   WIDTH-bit write data
//   pop      in   advance the head this edge; ignored while empty
//   dout     out  head entry, combinational
//   full     out  DEPTH entries held, decoded from registered pointers
//   empty    out  no entries held, decoded from registered pointers

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // A push while full is dropped even if a pop frees a slot on the same
  // edge, so a rejected byte never sneaks in behind the reader.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: nothing is read until the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1-style UART transmitter, LSB first, idle-high line
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset; abandons any frame, tx goes high
//   tx_start    in   push strobe; tx_data enters the FIFO on this edge unless tx_full
//   tx_data     in   byte to push
//   tx          out  serial line, registered
//   tx_full     out  FIFO full; a push this cycle is dropped
//   tx_busy     out  frame in progress or FIFO non-empty
//   tx_overrun  out  one-cycle pulse after a dropped push

module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx_overrun
);

  localparam int DIVISOR = baud_divisor(CLK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int STOP_W  = (MAX_STOP_BITS > 1) ? $clog2(MAX_STOP_BITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_n;
  logic [CNT_W-1:0]     baud_cnt;
  logic                 bit_end;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_n;
  logic [STOP_W-1:0]    stop_idx;
  logic [STOP_W-1:0]    stop_idx_n;
  logic                 tx_n;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_start),
    .din     (tx_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (tx_full),
    .empty   (fifo_empty)
  );

  // Baud counter: parked at 0 in IDLE so every frame starts on a fresh bit.
  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (state == ST_IDLE || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // Frame FSM state, shift register and the tx flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      tx       <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, which keeps tx a
  // plain flop while still dropping the line on the same edge as the pop.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    tx_n       = 1'b1;
    fifo_pop   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_dout;
          state_n  = ST_START;
          tx_n     = 1'b0;
        end
      end

      ST_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end

      ST_DATA: begin
        tx_n = shift[0];
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            state_n    = ST_STOP;
            stop_idx_n = '0;
            tx_n       = 1'b1;
          end else begin
            shift_n   = {1'b0, shift[DATA_BITS-1:1]};
            bit_idx_n = bit_idx + IDX_W'(1);
            tx_n      = shift[1];
          end
        end
      end

      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            state_n = ST_IDLE;
          end else begin
            stop_idx_n = stop_idx + STOP_W'(1);
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Busy covers queued bytes as well as the frame on the wire, so it rises
  // on the accepting edge and only falls once the last STOP is done.
  assign tx_busy = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_overrun <= 1'b0;
    end else begin
      tx_overrun <= tx_start && tx_full;
    end
  end

endmodule
